// File: rtl/pipe_add_sub.sv
// Pipelined adder/subtractor. Each stage resolves one CHUNK-bit slice of the
// result and passes its carry, the still-unresolved operand slices and the
// sub flag to the next stage. All stages advance together under a single
// enable derived from output backpressure.
module pipe_add_sub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             zero_o
);

    localparam int unsigned CHUNK = WIDTH / STAGES;

    // Stage registers (index k = output of stage k)
    logic             v_q [STAGES];
    logic             s_q [STAGES];
    logic             c_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] r_q [STAGES];
    logic             cout_q;
    logic             ovf_q;

    // Per-stage inputs (index 0 = block ports, index k = stage k-1 registers)
    logic             in_v [STAGES];
    logic             in_s [STAGES];
    logic             in_c [STAGES];
    logic [WIDTH-1:0] in_a [STAGES];
    logic [WIDTH-1:0] in_b [STAGES];
    logic [WIDTH-1:0] in_r [STAGES];

    // Per-stage next values
    logic [WIDTH-1:0] d_r [STAGES];
    logic             d_c [STAGES];
    logic [CHUNK:0]   sum;
    logic             cout_d;
    logic             ovf_d;
    logic             en;

    assign valid_o  = v_q[STAGES-1];
    assign result_o = r_q[STAGES-1];
    assign cout_o   = cout_q;
    assign ovf_o    = ovf_q;
    assign zero_o   = v_q[STAGES-1] & (r_q[STAGES-1] == '0);
    assign en       = ~valid_o | ready_i;
    assign ready_o  = en;

    // Route each stage's source: ports for stage 0, previous stage otherwise.
    // b is inverted on entry so subtraction becomes a + ~b + 1 with cin = sub.
    always_comb begin
        in_v[0] = valid_i;
        in_s[0] = sub_i;
        in_c[0] = sub_i;
        in_a[0] = a_i;
        in_b[0] = sub_i ? ~b_i : b_i;
        in_r[0] = '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            in_v[k] = v_q[k-1];
            in_s[k] = s_q[k-1];
            in_c[k] = c_q[k-1];
            in_a[k] = a_q[k-1];
            in_b[k] = b_q[k-1];
            in_r[k] = r_q[k-1];
        end
    end

    // Resolve one chunk per stage; flags come from the final stage's slice.
    always_comb begin
        sum = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            sum = {1'b0, in_a[k][k*CHUNK +: CHUNK]}
                + {1'b0, in_b[k][k*CHUNK +: CHUNK]}
                + (CHUNK+1)'(in_c[k]);
            d_r[k] = in_r[k];
            d_r[k][k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
            d_c[k] = sum[CHUNK];
        end
        // carry into MSB is a^b^sum at the MSB; overflow is that XOR carry out
        ovf_d  = in_a[STAGES-1][WIDTH-1] ^ in_b[STAGES-1][WIDTH-1]
               ^ d_r[STAGES-1][WIDTH-1] ^ d_c[STAGES-1];
        cout_d = d_c[STAGES-1] ^ in_s[STAGES-1];
    end

    // Advance every stage together when enabled; reset empties the pipe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                s_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (en) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                v_q[k] <= in_v[k];
                s_q[k] <= in_s[k];
                c_q[k] <= d_c[k];
                a_q[k] <= in_a[k];
                b_q[k] <= in_b[k];
                r_q[k] <= d_r[k];
            end
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipe_add_sub.sv
// Self-checking bench for pipe_add_sub (WIDTH=32, STAGES=4): directed corner
// cases, stall, reset flush and a randomized stream against a queue model.
module tb_pipe_add_sub;

    localparam int unsigned W = 32;
    localparam int unsigned S = 4;

    logic          clk_i;
    logic          rst_i;
    logic          valid_i;
    logic          ready_o;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic          sub_i;
    logic          valid_o;
    logic          ready_i;
    logic [W-1:0]  result_o;
    logic          cout_o;
    logic          ovf_o;
    logic          zero_o;

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    exp_t        q[$];
    int          tests;
    int          fails;
    int          run_len;
    int          max_run;
    bit          hold_valid;
    logic [31:0] hold_r;
    logic        hold_c;
    logic        hold_o;
    logic        hold_z;

    pipe_add_sub #(.WIDTH(W), .STAGES(S)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .a_i      (a_i),
        .b_i      (b_i),
        .sub_i    (sub_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .cout_o   (cout_o),
        .ovf_o    (ovf_o),
        .zero_o   (zero_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference: plain arithmetic on the operands.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        exp_t        e;
        logic [32:0] s;
        if (!sub) begin
            s   = {1'b0, a} + {1'b0, b};
            e.r = s[31:0];
            e.c = s[32];
            e.o = (a[31] == b[31]) && (e.r[31] != a[31]);
        end else begin
            e.r = a - b;
            e.c = (a < b);
            e.o = (a[31] != b[31]) && (e.r[31] != a[31]);
        end
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock of streaming traffic with scoreboard and hold checks.
    task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic rdy);
        bit   acc;
        exp_t e;
        valid_i = v;
        a_i     = a;
        b_i     = b;
        sub_i   = sub;
        ready_i = rdy;
        #1;
        if (hold_valid) begin
            check1 ("hold_valid", valid_o,  1'b1);
            check32("hold_result", result_o, hold_r);
            check1 ("hold_cout",  cout_o,   hold_c);
            check1 ("hold_ovf",   ovf_o,    hold_o);
            check1 ("hold_zero",  zero_o,   hold_z);
        end
        acc = v && ready_o;
        if (valid_o) begin
            if (q.size() == 0) begin
                check1("spurious_valid", valid_o, 1'b0);
            end else begin
                e = q[0];
                check32("result", result_o, e.r);
                check1 ("cout",   cout_o,   e.c);
                check1 ("ovf",    ovf_o,    e.o);
                check1 ("zero",   zero_o,   e.z);
                if (rdy) void'(q.pop_front());
            end
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        hold_valid = valid_o && !rdy;
        hold_r = result_o;
        hold_c = cout_o;
        hold_o = ovf_o;
        hold_z = zero_o;
        @(posedge clk_i);
        #1;
        if (acc) q.push_back(model(a, b, sub));
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (q.size() != 0 || valid_o); i++)
            cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        check32("drain_empty", 32'(q.size()), 32'd0);
        check1("drain_valid", valid_o, 1'b0);
    endtask

    // Single beat into an empty pipe; checks latency and flags.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic [31:0] er, input logic ec,
                           input logic eo, input logic ez);
        int n;
        valid_i = 1'b1;
        a_i     = a;
        b_i     = b;
        sub_i   = sub;
        ready_i = 1'b1;
        #1;
        check1({tag, "_ready"}, ready_o, 1'b1);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        n = 1;
        while (!valid_o && n < 20) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check32({tag, "_latency"}, 32'(n), 32'(S));
        check32({tag, "_result"}, result_o, er);
        check1 ({tag, "_cout"}, cout_o, ec);
        check1 ({tag, "_ovf"},  ovf_o,  eo);
        check1 ({tag, "_zero"}, zero_o, ez);
        @(posedge clk_i);
        #1;
        check1({tag, "_popped"}, valid_o, 1'b0);
    endtask

    logic [31:0] stream_a [8];
    logic [31:0] stream_b [8];
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] corner [4];

    initial begin
        tests = 0; fails = 0; run_len = 0; max_run = 0; hold_valid = 0;
        stream_a = '{32'h00000001, 32'h00003039, 32'hFFFFFFFF, 32'h12345678,
                     32'h80000000, 32'h00000000, 32'hDEADBEEF, 32'h7FFFFFFF};
        stream_b = '{32'h00000001, 32'h00001A85, 32'h00000002, 32'h87654321,
                     32'h80000000, 32'h00000000, 32'h21524111, 32'h7FFFFFFF};
        corner   = '{32'h00000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};

        // Reset state
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        a_i = '0; b_i = '0; sub_i = 1'b0;
        #1;
        check1 ("rst_valid", valid_o, 1'b0);
        check1 ("rst_ready", ready_o, 1'b1);
        check32("rst_result", result_o, 32'd0);
        check1 ("rst_cout", cout_o, 1'b0);
        check1 ("rst_ovf",  ovf_o,  1'b0);
        check1 ("rst_zero", zero_o, 1'b0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Directed corner cases
        run_one("add_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
        run_one("sub_borrow", 32'h0002F145, 32'h000F1206, 1'b1, 32'hFFF3DF3F, 1'b1, 1'b0, 1'b0);
        run_one("sub_small", 32'h0000000A, 32'h00000009, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0);
        run_one("add_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        run_one("sub_ovf", 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);

        // Back-to-back stream of 8 beats
        run_len = 0; max_run = 0;
        for (int i = 0; i < 8; i++) cycle(1'b1, stream_a[i], stream_b[i], 1'b0, 1'b1);
        drain();
        check32("stream_run", 32'(max_run), 32'd8);

        // Stall with pipeline full
        for (int i = 0; i < 4; i++) cycle(1'b1, stream_a[i], stream_b[i], 1'(i & 1), 1'b0);
        for (int i = 0; i < 6; i++) begin
            check1("stall_valid", valid_o, 1'b1);
            check1("stall_ready", ready_o, 1'b0);
            cycle(1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b0);
        end
        drain();

        // Reset with 3 beats in flight
        for (int i = 0; i < 3; i++) cycle(1'b1, stream_a[i], stream_b[i], 1'b0, 1'b1);
        rst_i = 1'b1;
        #1;
        check1 ("midrst_valid", valid_o, 1'b0);
        check1 ("midrst_ready", ready_o, 1'b1);
        check32("midrst_result", result_o, 32'd0);
        q.delete();
        hold_valid = 0;
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
            check1("postrst_valid", valid_o, 1'b0);
        end
        run_one("after_rst", 32'h00000001, 32'h00000001, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1);

        // Randomized traffic with random backpressure and bubbles
        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : $urandom;
            rb = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : $urandom;
            cycle(1'($urandom_range(3) != 0), ra, rb, 1'($urandom_range(1)),
                  1'($urandom_range(3) != 0));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_add_sub.md
PIPE_ADD_SUB -- requirements
Module: pipe_add_sub

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; legal values 8 to 64.
REQ-002 Parameter STAGES, default 4, number of pipeline stages; legal values 1 to WIDTH; WIDTH % STAGES SHALL be 0.
REQ-003 Derived constant CHUNK = WIDTH/STAGES SHALL be the bits resolved per stage.
REQ-004 Port clk_i  input  1  single clock, all state on rising edge.
REQ-005 Port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 Port valid_i  input  1  operand beat valid.
REQ-007 Port ready_o  output  1  block accepts a beat this cycle.
REQ-008 Port a_i  input  WIDTH  minuend or first addend.
REQ-009 Port b_i  input  WIDTH  subtrahend or second addend.
REQ-010 Port sub_i  input  1  0 = a+b, 1 = a-b.
REQ-011 Port valid_o  output  1  result beat valid.
REQ-012 Port ready_i  input  1  downstream accepts result.
REQ-013 Port result_o  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-014 Port cout_o  output  1  add: carry out; sub: borrow (1 when a < b unsigned).
REQ-015 Port ovf_o  output  1  two's-complement signed overflow.
REQ-016 Port zero_o  output  1  result_o equals 0.

Function
REQ-017 Subtraction SHALL be computed as a + ~b + 1; cout_o SHALL be inverted carry in sub mode and raw carry in add mode.
REQ-018 Stage k (k = 0..STAGES-1) SHALL resolve bits [k*CHUNK +: CHUNK] using carry registered by stage k-1; stage 0 uses carry-in = sub_i.
REQ-019 Unresolved operand chunks and the sub flag SHALL travel with each beat through the pipeline registers.
REQ-020 ovf_o SHALL be carry into MSB XOR carry out of MSB, computed in the final stage.
REQ-021 zero_o SHALL be derived from the registered full result, not from partial chunks.
REQ-022 Latency SHALL be exactly STAGES cycles from the accepting edge (valid_i & ready_o) to valid_o with no stall.
REQ-023 Throughput SHALL be one beat per cycle while ready_i is held 1.
REQ-024 Pipeline enable en = ~valid_o | ready_i; all stages advance together when en = 1 and hold when en = 0.
REQ-025 ready_o SHALL equal en; a beat with valid_i = 1 and ready_o = 0 SHALL not be captured.
REQ-026 Bubbles (valid_i = 0 when en = 1) SHALL propagate as stage-valid = 0 without disturbing neighbouring beats.
REQ-027 While valid_o = 1 and ready_i = 0, result_o, cout_o, ovf_o, zero_o SHALL remain stable.
REQ-028 Simultaneous output pop and input push in one cycle SHALL be accepted with no lost or duplicated beat.
REQ-029 Beats SHALL exit in acceptance order; no reordering.

Reset
REQ-030 rst_i = 1 SHALL immediately clear all stage-valid bits; valid_o = 0, result_o = 0, cout_o = 0, ovf_o = 0, zero_o = 0.
REQ-031 ready_o SHALL be 1 while rst_i = 1 de-asserted state is reached and all stages empty.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight beats; none SHALL appear on valid_o after release.
REQ-033 First beat after reset release SHALL be accepted on the first rising edge with valid_i = 1.

Verification (WIDTH = 32, STAGES = 4)
REQ-034 Add wrap: a = FFFFFFFF, b = 00000001, sub = 0 -> after 4 cycles result = 00000000, cout = 1, zero = 1, ovf = 0.
REQ-035 Sub borrow: a = 0002F145, b = 000F1206, sub = 1 -> result = FFF3DF3F, cout = 1, ovf = 0; and a = 0000000A, b = 00000009, sub = 1 -> result = 00000001, cout = 0.
REQ-036 Signed overflow: a = 7FFFFFFF, b = 00000001, sub = 0 -> result = 80000000, ovf = 1, cout = 0; a = 80000000, b = 00000001, sub = 1 -> result = 7FFFFFFF, ovf = 1.
REQ-037 Back-to-back stream of 8 beats (1+1, 3039+1A85, ...) with ready_i = 1 -> 8 consecutive valid_o cycles, results 00000002, 00004ABE, ... in order.
REQ-038 Stall: ready_i = 0 for 6 cycles with pipeline full -> ready_o = 0 after valid_o rises, outputs frozen, no beat lost after ready_i returns to 1.
REQ-039 Reset with 3 beats in flight -> valid_o = 0 throughout and after release; next beat 1-1 emerges as result = 00000000, cout = 0, zero = 1 exactly 4 cycles after acceptance.
